// File: rtl/or1200_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : or1200_fwd_pkg
// Brief    : Shared select encodings, scheduler state type and default widths
// Revision : 1.0
// ============================================================================
package or1200_fwd_pkg;

    localparam int AW_DEFAULT = 5;

    localparam logic [1:0] SEL_RF      = 2'd0;
    localparam logic [1:0] SEL_IMM     = 2'd1;
    localparam logic [1:0] SEL_EX_FORW = 2'd2;
    localparam logic [1:0] SEL_WB_FORW = 2'd3;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } fwd_state_t;

endpackage
`default_nettype wire

// File: rtl/or1200_fwd_cmp.sv
`default_nettype none
// ============================================================================
// Module   : or1200_fwd_cmp
// Brief    : Source/destination address match; r0 never matches
// Revision : 1.0
// ============================================================================
module or1200_fwd_cmp
    import or1200_fwd_pkg::*;
#(
    parameter int aw = AW_DEFAULT
)(
    input  logic          en,
    input  logic          valid,
    input  logic [aw-1:0] src_addr,
    input  logic [aw-1:0] dst_addr,
    output logic          match
);

    assign match = en & valid & (src_addr == dst_addr) & (src_addr != '0);

endmodule
`default_nettype wire

// File: rtl/or1200_fwd_sched.sv
`default_nettype none
// ============================================================================
// Module   : or1200_fwd_sched
// Brief    : ID-stage operand forwarding selects and load-use stall scheduler
// Revision : 1.0
// ============================================================================
module or1200_fwd_sched
    import or1200_fwd_pkg::*;
#(
    parameter int aw   = AW_DEFAULT,
    parameter int cntw = 16
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_freeze,
    input  logic            ex_freeze,
    input  logic            wb_freeze,
    input  logic            id_rfa_en,
    input  logic            id_rfb_en,
    input  logic [aw-1:0]   id_rfa_addr,
    input  logic [aw-1:0]   id_rfb_addr,
    input  logic            id_imm_b,
    input  logic            id_rfwb_en,
    input  logic [aw-1:0]   id_rd_addr,
    input  logic            id_is_load,
    input  logic            lsu_done,
    output logic [1:0]      sel_a,
    output logic [1:0]      sel_b,
    output logic            lu_stall,
    output logic            ex_rd_valid,
    output logic [aw-1:0]   ex_rd_addr,
    output logic            wb_rd_valid,
    output logic [aw-1:0]   wb_rd_addr,
    output logic [cntw-1:0] lu_stall_cnt
);

    fwd_state_t      r_state;
    logic            r_ex_rd_valid;
    logic [aw-1:0]   r_ex_rd_addr;
    logic            r_ex_is_load;
    logic            r_wb_rd_valid;
    logic [aw-1:0]   r_wb_rd_addr;
    logic [cntw-1:0] r_cnt;

    // Comparator index: bit1 selects operand (A/B), bit0 selects stage (EX/WB)
    logic [3:0]      w_match;
    logic            w_hz;
    logic            w_lu_stall;
    logic            w_id_go;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
        or1200_fwd_cmp #(.aw(aw)) u_cmp (
            .en       ((gi >= 2) ? id_rfb_en : id_rfa_en),
            .valid    ((gi % 2 == 1) ? r_wb_rd_valid : r_ex_rd_valid),
            .src_addr ((gi >= 2) ? id_rfb_addr : id_rfa_addr),
            .dst_addr ((gi % 2 == 1) ? r_wb_rd_addr : r_ex_rd_addr),
            .match    (w_match[gi])
        );
    end

    assign w_hz       = r_ex_is_load & (w_match[0] | (w_match[2] & ~id_imm_b));
    assign w_lu_stall = ((r_state == RUN) & w_hz & ~lsu_done) | (r_state == LU_WAIT);
    assign w_id_go    = ~id_freeze & ~w_lu_stall;

    // A load-matched operand reads RF while stalled; it re-resolves from WB later
    always_comb begin
        sel_a = SEL_RF;
        if (w_match[0])
            sel_a = (w_lu_stall && r_ex_is_load) ? SEL_RF : SEL_EX_FORW;
        else if (w_match[1])
            sel_a = SEL_WB_FORW;
    end

    always_comb begin
        sel_b = SEL_RF;
        if (id_imm_b)
            sel_b = SEL_IMM;
        else if (w_match[2])
            sel_b = (w_lu_stall && r_ex_is_load) ? SEL_RF : SEL_EX_FORW;
        else if (w_match[3])
            sel_b = SEL_WB_FORW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_ex_rd_valid <= 1'b0;
            r_ex_rd_addr  <= '0;
            r_ex_is_load  <= 1'b0;
            r_wb_rd_valid <= 1'b0;
            r_wb_rd_addr  <= '0;
            r_cnt         <= '0;
        end else begin
            if (!ex_freeze) begin
                r_ex_rd_valid <= id_rfwb_en & w_id_go;
                r_ex_rd_addr  <= id_rd_addr;
                r_ex_is_load  <= id_is_load & w_id_go;
            end
            if (!wb_freeze) begin
                r_wb_rd_valid <= r_ex_rd_valid & ~ex_freeze;
                r_wb_rd_addr  <= r_ex_rd_addr;
            end
            case (r_state)
                RUN:     if (w_hz && !lsu_done) r_state <= LU_WAIT;
                LU_WAIT: if (lsu_done)          r_state <= RUN;
                default:                        r_state <= RUN;
            endcase
            if (w_lu_stall && !(&r_cnt))
                r_cnt <= r_cnt + cntw'(1);
        end
    end

    assign lu_stall     = w_lu_stall;
    assign ex_rd_valid  = r_ex_rd_valid;
    assign ex_rd_addr   = r_ex_rd_addr;
    assign wb_rd_valid  = r_wb_rd_valid;
    assign wb_rd_addr   = r_wb_rd_addr;
    assign lu_stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_or1200_fwd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_or1200_fwd_sched
// Brief    : Directed vector bench for or1200_fwd_sched (plus a cntw=4 copy)
// Revision : 1.0
// ============================================================================
module tb_or1200_fwd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_freeze, ex_freeze, wb_freeze;
    logic        id_rfa_en, id_rfb_en, id_imm_b, id_rfwb_en, id_is_load, lsu_done;
    logic [4:0]  id_rfa_addr, id_rfb_addr, id_rd_addr;

    logic [1:0]  sel_a, sel_b;
    logic        lu_stall, ex_rd_valid, wb_rd_valid;
    logic [4:0]  ex_rd_addr, wb_rd_addr;
    logic [15:0] lu_stall_cnt;

    logic [1:0]  s4_sel_a, s4_sel_b;
    logic        s4_lu_stall, s4_ex_rd_valid, s4_wb_rd_valid;
    logic [4:0]  s4_ex_rd_addr, s4_wb_rd_addr;
    logic [3:0]  s4_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    or1200_fwd_sched dut (
        .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
        .wb_freeze(wb_freeze), .id_rfa_en(id_rfa_en), .id_rfb_en(id_rfb_en),
        .id_rfa_addr(id_rfa_addr), .id_rfb_addr(id_rfb_addr), .id_imm_b(id_imm_b),
        .id_rfwb_en(id_rfwb_en), .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
        .lsu_done(lsu_done), .sel_a(sel_a), .sel_b(sel_b), .lu_stall(lu_stall),
        .ex_rd_valid(ex_rd_valid), .ex_rd_addr(ex_rd_addr), .wb_rd_valid(wb_rd_valid),
        .wb_rd_addr(wb_rd_addr), .lu_stall_cnt(lu_stall_cnt)
    );

    or1200_fwd_sched #(.aw(5), .cntw(4)) dut4 (
        .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
        .wb_freeze(wb_freeze), .id_rfa_en(id_rfa_en), .id_rfb_en(id_rfb_en),
        .id_rfa_addr(id_rfa_addr), .id_rfb_addr(id_rfb_addr), .id_imm_b(id_imm_b),
        .id_rfwb_en(id_rfwb_en), .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
        .lsu_done(lsu_done), .sel_a(s4_sel_a), .sel_b(s4_sel_b), .lu_stall(s4_lu_stall),
        .ex_rd_valid(s4_ex_rd_valid), .ex_rd_addr(s4_ex_rd_addr), .wb_rd_valid(s4_wb_rd_valid),
        .wb_rd_addr(s4_wb_rd_addr), .lu_stall_cnt(s4_cnt)
    );

    typedef struct {
        logic       idf, exf, wbf, ae, be;
        logic [4:0] aa, ba;
        logic       imm, wbe;
        logic [4:0] rd;
        logic       ld, done;
        logic [1:0] ea, eb;
        logic       es, exv, wbv;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mkv(input logic idf, exf, wbf, ae, be,
                                 input logic [4:0] aa, ba,
                                 input logic imm, wbe,
                                 input logic [4:0] rd,
                                 input logic ld, done,
                                 input logic [1:0] ea, eb,
                                 input logic es, exv, wbv);
        vec_t v;
        v.idf = idf; v.exf = exf; v.wbf = wbf; v.ae = ae; v.be = be;
        v.aa = aa; v.ba = ba; v.imm = imm; v.wbe = wbe; v.rd = rd;
        v.ld = ld; v.done = done; v.ea = ea; v.eb = eb;
        v.es = es; v.exv = exv; v.wbv = wbv;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic idf, exf, wbf, ae, be,
                         input logic [4:0] aa, ba,
                         input logic imm, wbe,
                         input logic [4:0] rd,
                         input logic ld, done);
        id_freeze = idf; ex_freeze = exf; wb_freeze = wbf;
        id_rfa_en = ae; id_rfb_en = be; id_rfa_addr = aa; id_rfb_addr = ba;
        id_imm_b = imm; id_rfwb_en = wbe; id_rd_addr = rd;
        id_is_load = ld; lsu_done = done;
    endtask

    initial begin
        //               idf exf wbf ae be  aa  ba imm wbe  rd  ld dn | ea eb es exv wbv
        vecs[0]  = mkv(0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mkv(0, 0, 0, 0, 0,  0,  0, 0, 1,  5, 0, 0,  0, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 0, 0, 1, 0,  5,  0, 0, 1,  6, 0, 0,  2, 0, 0, 1, 0);
        vecs[3]  = mkv(0, 0, 0, 1, 1,  5,  6, 0, 0,  0, 0, 0,  3, 2, 0, 1, 1);
        vecs[4]  = mkv(0, 0, 0, 1, 1,  6,  6, 1, 1,  7, 0, 0,  3, 1, 0, 0, 1);
        vecs[5]  = mkv(0, 0, 0, 0, 1,  0,  7, 0, 1,  7, 0, 0,  0, 2, 0, 1, 0);
        vecs[6]  = mkv(0, 0, 0, 1, 1,  7,  7, 0, 1,  0, 0, 0,  2, 2, 0, 1, 1);
        vecs[7]  = mkv(0, 0, 0, 1, 1,  0,  7, 1, 1,  9, 0, 0,  0, 1, 0, 1, 1);
        vecs[8]  = mkv(1, 0, 0, 1, 1,  0,  9, 1, 1, 10, 0, 0,  0, 1, 0, 1, 1);
        vecs[9]  = mkv(0, 0, 0, 1, 1, 10,  9, 0, 0,  0, 0, 0,  0, 3, 0, 0, 1);
        vecs[10] = mkv(0, 0, 0, 0, 0,  0,  0, 0, 1, 11, 0, 0,  0, 0, 0, 0, 0);
        vecs[11] = mkv(0, 1, 0, 1, 0, 11,  0, 0, 1, 12, 0, 0,  2, 0, 0, 1, 0);
        vecs[12] = mkv(0, 0, 0, 1, 0, 11,  0, 0, 0,  0, 0, 0,  2, 0, 0, 1, 0);
        vecs[13] = mkv(0, 0, 0, 1, 0, 11,  0, 0, 0,  0, 0, 0,  3, 0, 0, 0, 1);
        vecs[14] = mkv(0, 0, 0, 0, 0,  0,  0, 0, 1, 13, 0, 0,  0, 0, 0, 0, 0);
        vecs[15] = mkv(0, 0, 1, 1, 0, 13,  0, 0, 0,  0, 0, 0,  2, 0, 0, 1, 0);
        vecs[16] = mkv(0, 0, 0, 1, 0, 13,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        #2;
        chk("rst_sel_a", sel_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_stall", lu_stall, 0);
        chk("rst_ex_valid", ex_rd_valid, 0);
        chk("rst_wb_valid", wb_rd_valid, 0);
        chk("rst_ex_addr", ex_rd_addr, 0);
        chk("rst_wb_addr", wb_rd_addr, 0);
        chk("rst_cnt", lu_stall_cnt, 0);
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].idf, vecs[i].exf, vecs[i].wbf, vecs[i].ae, vecs[i].be,
                  vecs[i].aa, vecs[i].ba, vecs[i].imm, vecs[i].wbe, vecs[i].rd,
                  vecs[i].ld, vecs[i].done);
            #2;
            chk($sformatf("v%0d_sel_a", i), sel_a, vecs[i].ea);
            chk($sformatf("v%0d_sel_b", i), sel_b, vecs[i].eb);
            chk($sformatf("v%0d_stall", i), lu_stall, vecs[i].es);
            chk($sformatf("v%0d_ex_valid", i), ex_rd_valid, vecs[i].exv);
            chk($sformatf("v%0d_wb_valid", i), wb_rd_valid, vecs[i].wbv);
            tick();
        end

        // Load-use: load r3 enters EX, dependent instruction waits with EX held
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0); #2;
        chk("lu_pre_stall", lu_stall, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, (c < 2), 0, 1, 0, 3, 0, 0, 1, 4, 0, (c == 2)); #2;
            chk($sformatf("lu_c%0d_stall", c), lu_stall, 1);
            chk($sformatf("lu_c%0d_sel_a", c), sel_a, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0); #2;
        chk("lu_post_stall", lu_stall, 0);
        chk("lu_post_sel_a", sel_a, 3);
        chk("lu_post_wb_valid", wb_rd_valid, 1);
        chk("lu_cnt", lu_stall_cnt, 3);
        tick();

        // Load completing in the same cycle as the dependent read: no stall
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0); tick();
        drive(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1); #2;
        chk("lu_done_now_stall", lu_stall, 0);
        chk("lu_done_now_sel_a", sel_a, 2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("lu_done_now_cnt", lu_stall_cnt, 3);
        tick();

        // Asynchronous reset while in LU_WAIT
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0); tick();
        drive(0, 1, 0, 1, 1, 3, 3, 0, 0, 0, 0, 0); #2;
        chk("rw_stall_before", lu_stall, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rw_stall", lu_stall, 0);
        chk("rw_sel_a", sel_a, 0);
        chk("rw_sel_b", sel_b, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("rw_cnt", lu_stall_cnt, 0);
        chk("rw_cnt4", s4_cnt, 0);
        tick();

        // Counter saturation: 20 then 21 stall cycles
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0); tick();
        drive(0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        repeat (20) tick();
        #2;
        chk("sat_stall", lu_stall, 1);
        chk("sat_cnt4_20", s4_cnt, 15);
        chk("sat_cnt_20", lu_stall_cnt, 20);
        tick();
        #2;
        chk("sat_cnt4_21", s4_cnt, 15);
        chk("sat_cnt_21", lu_stall_cnt, 21);
        // lsu_done with EX still frozen must still return to RUN
        drive(0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("frz_done_run", lu_stall, 0);
        chk("frz_done_cnt", lu_stall_cnt, 22);
        chk("frz_done_cnt4", s4_cnt, 15);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
